// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Grants come from a direct select or a round-robin scan, and the result is held in a single output register.
module mux_n_rr #(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] ch_data [N];

  // Scans downwards so that the valid channel nearest ptr (in wrap order) is the last assignment.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] p, input logic [N-1:0] v);
    logic [SEL_W-1:0] pick;
    int               c;
    pick = p;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(p) + k;
      if (c >= N) c = c - N;
      else        c = c;
      if (v[c[SEL_W-1:0]]) pick = c[SEL_W-1:0];
      else                 pick = pick;
    end
    return pick;
  endfunction

  // Unpack the flat input bus into per-channel words
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant selection and handshake; in_ready is held low while in reset
  always_comb begin
    load = !out_valid || out_ready;
    if (mode) begin
      gnt     = rr_pick(ptr, in_valid);
      gnt_vld = |in_valid;
    end else begin
      gnt     = sel;
      gnt_vld = (int'(sel) < N) ? in_valid[sel] : 1'b0;
    end
    xfer     = rst_n && load && gnt_vld;
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
    else      in_ready = '0;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_ch    <= {SEL_W{1'b0}};
      ptr       <= {SEL_W{1'b0}};
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt];
        out_ch    <= gnt;
        if (mode) begin
          if (int'(gnt) == N - 1) ptr <= {SEL_W{1'b0}};
          else                    ptr <= gnt + SEL_W'(1);
        end else begin
          ptr <= ptr;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule
